// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
package timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned PSC_W  = 8;
  localparam int unsigned CTRL_W = 4;

  // Register offsets (word index taken from addr[3:2])
  localparam logic [1:0] CTRL_OFS   = 2'd0;
  localparam logic [1:0] PRESET_OFS = 2'd1;
  localparam logic [1:0] COUNT_OFS  = 2'd2;
  localparam logic [1:0] PSC_OFS    = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;

  // MODE codes; anything other than auto-reload behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Byte-lane merge of a bus write into an existing register value
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// Data-bus port between the system bridge (master) and the timer (slave).
interface timer_dev_if;
  import timer_pkg::*;

  logic              sel;
  logic [DATA_W-1:0] addr;
  logic [BE_W-1:0]   byteen;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output sel, output addr, output byteen, output wdata, input rdata);
  modport slave  (input sel, input addr, input byteen, input wdata, output rdata);
endinterface

// File: rtl/timer_prescaler.sv
// Tick divider for the timer: one tick every (psc+1) cycles, restarted by i_load.
// Only built when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [PSC_W-1:0] i_psc,
  output logic             o_tick_c
);

  logic [PSC_W-1:0] r_cnt;

  // Tick when the down-counter has run out and is not being restarted
  assign o_tick_c = !i_load && (r_cnt == '0);

  // Down-counter reloaded on restart and after every tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load || o_tick_c) begin
      r_cnt <= i_psc;
    end else begin
      r_cnt <= r_cnt - PSC_W'(1);
    end
  end

endmodule
`endif

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a
// maskable interrupt. Define TIMER_PRESCALE_EN to add the PSC register at
// 0xC and a tick prescaler; otherwise the counter ticks every cycle.
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus,
  output logic        irq
);

  state_e              r_state;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_preset;
  logic [DATA_W-1:0]   r_count;
  logic                r_flag;
  logic                r_irq;

  logic                w_wr;
  logic                w_ctrl_wr;
  logic                w_preset_wr;
  logic [CTRL_W-1:0]   w_ctrl_merged;
  logic [CTRL_W-1:0]   w_ctrl_nxt;
  logic [DATA_W-1:0]   w_preset_merged;
  logic                w_oneshot;
  logic                w_tick;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused_addr;

  // Bus write decode; only addr[3:2] selects a register
  assign w_wr            = bus.sel && (bus.byteen != '0);
  assign w_ctrl_wr       = w_wr && (bus.addr[3:2] == CTRL_OFS);
  assign w_preset_wr     = w_wr && (bus.addr[3:2] == PRESET_OFS);
  assign w_ctrl_merged   = bus.byteen[0] ? bus.wdata[CTRL_W-1:0] : r_ctrl;
  assign w_preset_merged = merge_bytes(r_preset, bus.wdata, bus.byteen);
  assign w_oneshot       = (r_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] != MODE_RELOAD);
  assign w_unused_addr   = ^{bus.addr[DATA_W-1:4], bus.addr[1:0]};

`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0] r_psc;
  logic             w_psc_wr;
  logic [PSC_W-1:0] w_psc_merged;

  assign w_psc_wr     = w_wr && (bus.addr[3:2] == PSC_OFS);
  assign w_psc_merged = bus.byteen[0] ? bus.wdata[PSC_W-1:0] : r_psc;

  timer_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .i_load   (r_state == ST_LOAD),
    .i_psc    (r_psc),
    .o_tick_c (w_tick)
  );

  // Prescale register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_psc <= '0;
    end else if (w_psc_wr) begin
      r_psc <= w_psc_merged;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Next CTRL value: one-shot expiry clears EN, a CPU write overrides it
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    if ((r_state == ST_INT) && w_oneshot) w_ctrl_nxt[CTRL_EN_BIT] = 1'b0;
    if (w_ctrl_wr) w_ctrl_nxt = w_ctrl_merged;
  end

  // Combinational read mux; returns pre-edge values during a write
  always_comb begin
    w_rdata = '0;
    case (bus.addr[3:2])
      CTRL_OFS:   w_rdata = DATA_W'(r_ctrl);
      PRESET_OFS: w_rdata = r_preset;
      COUNT_OFS:  w_rdata = r_count;
`ifdef TIMER_PRESCALE_EN
      PSC_OFS:    w_rdata = DATA_W'(r_psc);
`else
      PSC_OFS:    w_rdata = '0;
`endif
      default:    w_rdata = '0;
    endcase
  end

  assign bus.rdata = w_rdata;
  assign irq       = r_irq;

  // Register file, countdown FSM, expiry flag and interrupt output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_ctrl   <= '0;
      r_preset <= RESET_PRESET;
      r_count  <= '0;
      r_flag   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_ctrl <= w_ctrl_nxt;
      if (w_preset_wr) r_preset <= w_preset_merged;
      // CPU writes acknowledge the flag; an expiry in the same cycle still sets it
      if (w_ctrl_wr || w_preset_wr) r_flag <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // Start on the same edge that writes EN=1
          if (w_ctrl_nxt[CTRL_EN_BIT]) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!r_ctrl[CTRL_EN_BIT]) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            if (r_count == '0) begin
              r_flag  <= 1'b1;
              r_state <= ST_INT;
            end else begin
              r_count <= r_count - DATA_W'(1);
            end
          end
        end
        ST_INT: begin
          if (w_oneshot) begin
            r_state <= ST_IDLE;
          end else begin
            r_flag  <= 1'b0;
            r_state <= ST_LOAD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      r_irq <= r_flag & r_ctrl[CTRL_IM_BIT];
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: register vector table plus
// hand-written countdown, reload, mask and reset sequences.
module tb_timer_dev;

  localparam logic [31:0] RST_PRE = 32'hA5A5_0000;
`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] PSC_RB = 32'h0000_00FF;
`else
  localparam logic [31:0] PSC_RB = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic reset;
  logic irq;
  int   n_chk = 0;
  int   n_err = 0;

  timer_dev_if bus ();

  timer_dev #(.RESET_PRESET(RST_PRE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus write, taking effect at the next rising edge; returns at edge+1
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.sel = 1'b1; bus.addr = a; bus.wdata = d; bus.byteen = be;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.byteen = 4'h0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(nm, bus.rdata, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{32'h0000_0004, 32'h1122_3344, 4'hF, 32'h1122_3344};
    tbl[1] = '{32'h0000_0004, 32'hAABB_CCDD, 4'h4, 32'h11BB_3344};
    tbl[2] = '{32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    tbl[3] = '{32'h1234_0005, 32'h0000_0055, 4'h1, 32'h11BB_3355};
    tbl[4] = '{32'h0000_0000, 32'hFFFF_FFF6, 4'hF, 32'h0000_0006};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000, 4'h1, 32'h0000_0000};
    tbl[6] = '{32'h0000_000C, 32'hFFFF_FFFF, 4'hF, PSC_RB};
    tbl[7] = '{32'h0000_0004, 32'hFFFF_FFFF, 4'h0, 32'h11BB_3355};
    tbl[8] = '{32'hFFFF_FFF4, 32'h1234_5678, 4'h8, 32'h12BB_3355};

    reset = 1'b0;
    bus.sel = 1'b0; bus.addr = '0; bus.byteen = '0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("irq_in_reset", {31'b0, irq}, 32'h0);
    reset = 1'b1;
    rd_chk("rst_ctrl", 32'h0, 32'h0);
    rd_chk("rst_preset", 32'h4, RST_PRE);
    rd_chk("rst_count", 32'h8, 32'h0);
    rd_chk("rst_psc", 32'hC, 32'h0);
    step();

    // Register access table
    for (int i = 0; i < 9; i++) begin
      wr(tbl[i].addr, tbl[i].wdata, tbl[i].be);
      rd_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
      step();
    end
    wr(32'hC, 32'h0, 4'hF);

    // Read during a write cycle returns the old value
    bus.sel = 1'b1; bus.addr = 32'h4; bus.wdata = 32'hDEAD_BEEF; bus.byteen = 4'hF;
    #1;
    chk("rd_during_wr", bus.rdata, 32'h12BB_3355);
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.byteen = 4'h0;
    chk("rd_after_wr", bus.rdata, 32'hDEAD_BEEF);

    // One-shot PRESET=5: irq rises 8 edges after the CTRL write
    wr(32'h4, 32'd5, 4'hF);
    wr(32'h0, 32'h9, 4'hF);
    bus.addr = 32'h8;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("os_count_k%0d", k), bus.rdata, (k <= 6) ? 32'(6 - k) : 32'h0);
      chk($sformatf("os_irq_k%0d", k), {31'b0, irq}, {31'b0, (k >= 8)});
    end
    rd_chk("os_ctrl", 32'h0, 32'h8);
    rd_chk("os_count_end", 32'h8, 32'h0);

    // Asynchronous reset drops a live irq without a clock edge
    #3 reset = 1'b0;
    #1;
    chk("areset_irq", {31'b0, irq}, 32'h0);
    rd_chk("areset_ctrl", 32'h0, 32'h0);
    rd_chk("areset_preset", 32'h4, RST_PRE);
    reset = 1'b1;
    step();

    // PRESET=0: LOAD, CNT, INT on consecutive edges
    wr(32'h4, 32'd0, 4'hF);
    wr(32'h0, 32'h9, 4'hF);
    step();
    step();
    chk("p0_irq_e2", {31'b0, irq}, 32'h0);
    step();
    chk("p0_irq_e3", {31'b0, irq}, 32'h1);

    // Auto-reload PRESET=3: single-cycle irq every 6 cycles
    wr(32'h0, 32'h8, 4'hF);
    wr(32'h4, 32'd3, 4'hF);
    wr(32'h0, 32'hB, 4'hF);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("ar_irq_k%0d", k), {31'b0, irq}, {31'b0, (k >= 6) && ((k % 6) == 0)});
    end
    rd_chk("ar_ctrl", 32'h0, 32'hB);
    step();
    wr(32'h0, 32'h0, 4'hF);

    // Masked expiry, then CTRL write clears the flag before IM is set
    wr(32'h4, 32'd2, 4'hF);
    wr(32'h0, 32'h1, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("mask_irq_k%0d", k), {31'b0, irq}, 32'h0);
    end
    rd_chk("mask_ctrl", 32'h0, 32'h0);
    step();
    wr(32'h0, 32'h8, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("clr_irq_k%0d", k), {31'b0, irq}, 32'h0);
    end

    // Reset at COUNT=50 of a PRESET=100 run
    wr(32'h4, 32'd100, 4'hF);
    wr(32'h0, 32'h9, 4'hF);
    repeat (51) step();
    rd_chk("mid_count50", 32'h8, 32'd50);
    #3 reset = 1'b0;
    #1;
    chk("mid_irq", {31'b0, irq}, 32'h0);
    rd_chk("mid_ctrl", 32'h0, 32'h0);
    rd_chk("mid_count", 32'h8, 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("mid_idle_k%0d", k), bus.rdata, 32'h0);
    end

`ifdef TIMER_PRESCALE_EN
    // PSC=3: COUNT steps every 4 cycles, PRESET=2 expires at edge 13
    wr(32'hC, 32'd3, 4'hF);
    wr(32'h4, 32'd2, 4'hF);
    wr(32'h0, 32'h9, 4'hF);
    bus.addr = 32'h8;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("psc_count_k%0d", k), bus.rdata,
          (k <= 4) ? 32'd2 : ((k <= 8) ? 32'd1 : 32'd0));
      chk($sformatf("psc_irq_k%0d", k), {31'b0, irq}, {31'b0, (k >= 14)});
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
